// File: rtl/serial_display_ctrl.sv
// ---------------------------------------------------------------------------
// serial_display_ctrl
//
// Purpose:
//   Drives an N-digit 7-segment tube and an M-bit LED bar. Each sits on its
//   own serial shift-register chain (clk / clr_n / data / en). Once per frame
//   the block takes a snapshot of the digit and LED inputs and encodes each
//   digit according to the display mode. It then shifts both chains out
//   MSB-first, using a serial clock divided down from the main clock.
//   A frame is requested by the free-running refresh counter or by an
//   explicit update pulse.
//
// Ports:
//   clk, rst_n            main clock, asynchronous active-low reset
//   mode[1:0]             00 hex, 01 raw, 10 blank, 11 lamp test
//   data[4*ND-1:0]        hex nibble per digit
//   seg_raw[8*ND-1:0]     raw segment byte {dp,g..a} per digit
//   en[ND-1:0]            per-digit enable (0 = blank)
//   dot[ND-1:0]           per-digit decimal point (hex mode)
//   led[LN-1:0]           LED bar image, 1 = lit
//   update                one-cycle frame request
//   busy, done            frame in progress / one-cycle end-of-frame pulse
//   led_clk/do/clr_n/en   LED chain pins
//   seg_clk/do/clr_n/en   segment chain pins
//
// Configuration:
//   DISP_BLINK_EN  When defined, adds the blink[ND-1:0] input and the
//                  BLINK_FRAMES parameter. Digits flagged in blink are blanked
//                  during the off phase. The phase toggles every BLINK_FRAMES
//                  completed frames.
// ---------------------------------------------------------------------------
module serial_display_ctrl #(
  parameter int CLK_FREQ   = 25,
  parameter int S_CLK_FREQ = 5,
  parameter int NUM_DIGITS = 8,
  parameter int LED_BITS   = 16,
  parameter int REFRESH_MS = 100,
  parameter int ACTIVE_LOW = 1
`ifdef DISP_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 5
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [8*NUM_DIGITS-1:0]   seg_raw,
  input  logic [NUM_DIGITS-1:0]     en,
  input  logic [NUM_DIGITS-1:0]     dot,
  input  logic [LED_BITS-1:0]       led,
`ifdef DISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink,
`endif
  input  logic                      update,
  output logic                      busy,
  output logic                      done,
  output logic                      led_clk,
  output logic                      led_do,
  output logic                      led_clr_n,
  output logic                      led_en,
  output logic                      seg_clk,
  output logic                      seg_do,
  output logic                      seg_clr_n,
  output logic                      seg_en
);

  localparam int HALF_RAW    = CLK_FREQ / (2 * S_CLK_FREQ);
  localparam int HALF        = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int SLOT        = 2 * HALF;
  localparam int SN          = 8 * NUM_DIGITS;
  localparam int LN          = LED_BITS;
  localparam int MAXN        = (SN > LN) ? SN : LN;
  localparam int REFRESH_CYC = CLK_FREQ * REFRESH_MS * 1000;
  localparam int PH_W        = $clog2(SLOT);
  localparam int SLOT_W      = $clog2(MAXN + 1);
  localparam int REF_W       = $clog2(REFRESH_CYC + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SLOT - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(HALF);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAXN - 1);
  localparam logic [SLOT_W-1:0] SN_C      = SLOT_W'(SN);
  localparam logic [SLOT_W-1:0] LN_C      = SLOT_W'(LN);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYC - 1);
  localparam logic              INV       = (ACTIVE_LOW != 0);

`ifdef DISP_BLINK_EN
  localparam int                BL_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [BL_W-1:0]   BL_LAST = BL_W'(BLINK_FRAMES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CLEAR  = 3'd2,
    SHIFT  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SN-1:0]       seg_sr_q, seg_sr_d;
  logic [LN-1:0]       led_sr_q, led_sr_d;
  logic                clr_n_q, clr_n_d;
  logic                pending_q, pending_d;
  logic [REF_W-1:0]    refresh_q, refresh_d;
`ifdef DISP_BLINK_EN
  logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_off_q, blink_off_d;
`endif

  logic [SN-1:0]       seg_img;
  logic [LN-1:0]       led_img;
  logic [7:0]          dig_byte;
  logic                refresh_tc;
  logic                req;
  logic                seg_act;
  logic                led_act;
  logic                clk_high;

  // Segment pattern {g,f,e,d,c,b,a} for a hex nibble, lit = 1.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Frame image encoded from the live inputs. It is only captured into the
  // shift registers in LOAD, so later input changes cannot disturb a frame.
  // Lamp test lights everything and overrides both en and blink.
  always_comb begin
    seg_img  = '0;
    dig_byte = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      case (mode)
        2'b00:   dig_byte = en[i] ? {dot[i], hex7(data[4*i +: 4])} : 8'h00;
        2'b01:   dig_byte = en[i] ? seg_raw[8*i +: 8] : 8'h00;
        2'b10:   dig_byte = 8'h00;
        default: dig_byte = 8'hFF;
      endcase
`ifdef DISP_BLINK_EN
      if (mode != 2'b11 && blink_off_q && blink[i]) begin
        dig_byte = 8'h00;
      end
`endif
      seg_img[8*i +: 8] = dig_byte;
    end
    led_img = (mode == 2'b11) ? '1 : led;
  end

  // Frame sequencer plus the refresh/pending request logic. The segment
  // register is packed with digit ND-1 in its top byte, so a plain left shift
  // yields digit ND-1 first and dp first within each byte.
  // The LOAD/CLEAR/SHIFT/FINISH states all count as busy. A request that
  // arrives in any of them is remembered in one pending flag and is picked
  // up in the IDLE cycle that follows done.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    slot_d    = slot_q;
    seg_sr_d  = seg_sr_q;
    led_sr_d  = led_sr_q;
    clr_n_d   = clr_n_q;
    pending_d = pending_q;
`ifdef DISP_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
`endif

    refresh_tc = (refresh_q == REF_LAST);
    refresh_d  = refresh_tc ? '0 : refresh_q + 1'b1;
    req        = refresh_tc || update;

    case (state_q)
      IDLE: begin
        if (pending_q || req) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        seg_sr_d = seg_img;
        led_sr_d = led_img;
        clr_n_d  = 1'b0;
        phase_d  = '0;
        state_d  = CLEAR;
      end
      CLEAR: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          slot_d  = '0;
          clr_n_d = 1'b1;
          state_d = SHIFT;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          seg_sr_d = seg_sr_q << 1;
          led_sr_d = led_sr_q << 1;
          if (slot_q == SLOT_LAST) begin
            state_d = FINISH;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
`ifdef DISP_BLINK_EN
        if (blink_cnt_q == BL_LAST) begin
          blink_cnt_d = '0;
          blink_off_d = !blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && req) begin
      pending_d = 1'b1;
    end
  end

  // State and datapath registers. The pending flag comes out of reset set,
  // so a full frame is pushed out as soon as reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      slot_q    <= '0;
      seg_sr_q  <= '0;
      led_sr_q  <= '0;
      clr_n_q   <= 1'b0;
      pending_q <= 1'b1;
      refresh_q <= '0;
`ifdef DISP_BLINK_EN
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      slot_q    <= slot_d;
      seg_sr_q  <= seg_sr_d;
      led_sr_q  <= led_sr_d;
      clr_n_q   <= clr_n_d;
      pending_q <= pending_d;
      refresh_q <= refresh_d;
`ifdef DISP_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
`endif
    end
  end

  // Pin decode. The pins are derived only from flops, so an asynchronous
  // reset forces them low straight away. A chain whose bits are used up
  // stays quiet (clk=0, do=0) while the longer chain finishes.
  always_comb begin
    seg_act  = (state_q == SHIFT) && (slot_q < SN_C);
    led_act  = (state_q == SHIFT) && (slot_q < LN_C);
    clk_high = (phase_q >= PH_HALF);
  end

  assign seg_clk   = seg_act && clk_high;
  assign led_clk   = led_act && clk_high;
  assign seg_do    = seg_act && (seg_sr_q[SN-1] ^ INV);
  assign led_do    = led_act && (led_sr_q[LN-1] ^ INV);
  assign seg_clr_n = clr_n_q;
  assign led_clr_n = clr_n_q;
  assign seg_en    = 1'b1;
  assign led_en    = 1'b1;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_serial_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_display_ctrl
//
// Purpose:
//   Directed bench for serial_display_ctrl in its default build (ND=8,
//   LN=16, HALF=2, ACTIVE_LOW=1). A negedge monitor rebuilds the serial
//   words from the pins. Each frame's words, clock-edge counts, length and
//   done pulses are then compared against hand-computed values.
//   Frame length = 1 + 4*(1+64) + 1 = 262 cycles.
// ---------------------------------------------------------------------------
module tb_serial_display_ctrl;

  localparam int FRAME_LEN = 262;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [31:0] data;
  logic [63:0] seg_raw;
  logic [7:0]  en;
  logic [7:0]  dot;
  logic [15:0] led;
  logic        update;
  logic        busy;
  logic        done;
  logic        led_clk;
  logic        led_do;
  logic        led_clr_n;
  logic        led_en;
  logic        seg_clk;
  logic        seg_do;
  logic        seg_clr_n;
  logic        seg_en;

  int checks = 0;
  int errors = 0;

  // Monitor state; only the monitor process writes these.
  logic [63:0] seg_word;
  logic [15:0] led_word;
  int          seg_rises;
  int          led_rises;
  int          busy_cyc;
  int          done_cnt;
  int          clr_low;
  logic        prev_seg_clk;
  logic        prev_led_clk;
  int          clear_req = 0;
  int          clear_ack = 0;

  serial_display_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .data      (data),
    .seg_raw   (seg_raw),
    .en        (en),
    .dot       (dot),
    .led       (led),
    .update    (update),
    .busy      (busy),
    .done      (done),
    .led_clk   (led_clk),
    .led_do    (led_do),
    .led_clr_n (led_clr_n),
    .led_en    (led_en),
    .seg_clk   (seg_clk),
    .seg_do    (seg_do),
    .seg_clr_n (seg_clr_n),
    .seg_en    (seg_en)
  );

  // 10 ns main clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pin monitor. Samples at the falling edge, away from the DUT's active
  // edge. A data bit is captured on each rising edge of a serial clock.
  always @(negedge clk) begin
    if (clear_req != clear_ack) begin
      clear_ack    = clear_req;
      seg_word     = '0;
      led_word     = '0;
      seg_rises    = 0;
      led_rises    = 0;
      busy_cyc     = 0;
      done_cnt     = 0;
      clr_low      = 0;
      prev_seg_clk = seg_clk;
      prev_led_clk = led_clk;
    end else begin
      if (seg_clk && !prev_seg_clk) begin
        seg_word  = {seg_word[62:0], seg_do};
        seg_rises = seg_rises + 1;
      end
      if (led_clk && !prev_led_clk) begin
        led_word  = {led_word[14:0], led_do};
        led_rises = led_rises + 1;
      end
      if (busy) busy_cyc = busy_cyc + 1;
      if (done) done_cnt = done_cnt + 1;
      if (busy && !seg_clr_n && !led_clr_n) clr_low = clr_low + 1;
      prev_seg_clk = seg_clk;
      prev_led_clk = led_clk;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives a complete set of display inputs.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] d, input logic [63:0] r,
                               input logic [7:0] e, input logic [7:0] dp, input logic [15:0] l);
    mode    = m;
    data    = d;
    seg_raw = r;
    en      = e;
    dot     = dp;
    led     = l;
  endtask

  task automatic clearStats();
    clear_req = clear_req + 1;
    @(negedge clk);
    #1;
  endtask

  task automatic pulseUpdate();
    @(posedge clk);
    #2 update = 1'b1;
    @(posedge clk);
    #2 update = 1'b0;
  endtask

  task automatic waitBusy(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    checkOutput({tag, ".start"}, 64'(seen), 64'd1);
  endtask

  task automatic waitIdle(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (!busy) seen = 1'b1;
    end
    checkOutput({tag, ".end"}, 64'(seen), 64'd1);
  endtask

  task automatic checkFrame(input string tag, input logic [63:0] exp_seg, input logic [15:0] exp_led);
    checkOutput({tag, ".len"},      64'(busy_cyc),  64'(FRAME_LEN));
    checkOutput({tag, ".seg"},      seg_word,       exp_seg);
    checkOutput({tag, ".led"},      64'(led_word),  64'(exp_led));
    checkOutput({tag, ".seg_rise"}, 64'(seg_rises), 64'd64);
    checkOutput({tag, ".led_rise"}, 64'(led_rises), 64'd16);
    checkOutput({tag, ".done"},     64'(done_cnt),  64'd1);
  endtask

  task automatic runFrame(input string tag, input logic [63:0] exp_seg, input logic [15:0] exp_led);
    clearStats();
    pulseUpdate();
    waitBusy(tag);
    waitIdle(tag);
    checkFrame(tag, exp_seg, exp_led);
  endtask

  initial begin
    bit reached;
    rst_n  = 1'b0;
    update = 1'b0;
    applyStimulus(2'b00, 32'h01234567, 64'h0, 8'hFF, 8'h00, 16'hA5C3);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst.busy",  64'(busy),      64'd0);
    checkOutput("rst.done",  64'(done),      64'd0);
    checkOutput("rst.clks",  64'({seg_clk, led_clk}),     64'd0);
    checkOutput("rst.do",    64'({seg_do, led_do}),       64'd0);
    checkOutput("rst.clr_n", 64'({seg_clr_n, led_clr_n}), 64'd0);
    checkOutput("rst.en",    64'({seg_en, led_en}),       64'd3);
    clearStats();

    // Release: the pending frame starts on the first edge.
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rel.idle", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("rel.busy", 64'(busy), 64'd1);
    waitIdle("hex");
    checkFrame("hex", 64'hC0F9A4B0999282F8, 16'h5A3C);

    // Upper four digits disabled; clear pulse length on a normal frame.
    applyStimulus(2'b00, 32'h01234567, 64'h0, 8'h0F, 8'h00, 16'hA5C3);
    runFrame("en0F", 64'hFFFFFFFF999282F8, 16'h5A3C);
    checkOutput("en0F.clr_len", 64'(clr_low), 64'd4);

    // Lamp test overrides en, lights all LEDs.
    applyStimulus(2'b11, 32'h01234567, 64'h0, 8'h00, 8'h00, 16'h1234);
    runFrame("lamp", 64'h0, 16'h0000);

    // Raw and blank modes.
    applyStimulus(2'b01, 32'h0, 64'h0123456789ABCDEF, 8'hFF, 8'h00, 16'h00FF);
    runFrame("raw", 64'hFEDCBA9876543210, 16'hFF00);
    applyStimulus(2'b10, 32'h01234567, 64'h0123456789ABCDEF, 8'hFF, 8'hFF, 16'h00FF);
    runFrame("blank", 64'hFFFFFFFFFFFFFFFF, 16'hFF00);

    // Hex with decimal point; inputs changed mid-frame must not leak in.
    applyStimulus(2'b00, 32'h89ABCDEF, 64'h0, 8'hFF, 8'h80, 16'h8001);
    clearStats();
    pulseUpdate();
    waitBusy("snap");
    repeat (5) @(posedge clk);
    #2 applyStimulus(2'b11, 32'h0, 64'h0, 8'h00, 8'hFF, 16'hFFFF);
    waitIdle("snap");
    checkFrame("snap", 64'h00908883C6A1868E, 16'h7FFE);

    // Three requests while busy collapse into one extra frame.
    applyStimulus(2'b00, 32'h01234567, 64'h0, 8'hFF, 8'h00, 16'hA5C3);
    clearStats();
    pulseUpdate();
    waitBusy("pend");
    pulseUpdate();
    pulseUpdate();
    pulseUpdate();
    waitIdle("pend");
    checkOutput("pend.done", 64'(done_cnt), 64'd1);
    @(negedge clk);
    #1;
    checkOutput("pend.restart", 64'(busy), 64'd1);
    waitIdle("pend2");
    clearStats();
    repeat (300) @(negedge clk);
    #1;
    checkOutput("pend.no_more", 64'(busy_cyc), 64'd0);

    // Reset during SHIFT slot 20, then a fresh full frame.
    clearStats();
    pulseUpdate();
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clk);
      #1;
      if (seg_rises >= 21) reached = 1'b1;
    end
    checkOutput("mid.reach", 64'(reached), 64'd1);
    checkOutput("mid.pre_clk", 64'(seg_clk), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid.clks",  64'({seg_clk, led_clk}), 64'd0);
    checkOutput("mid.do",    64'({seg_do, led_do}),   64'd0);
    checkOutput("mid.busy",  64'(busy),               64'd0);
    checkOutput("mid.clr_n", 64'({seg_clr_n, led_clr_n}), 64'd0);
    applyStimulus(2'b00, 32'hFEDCBA98, 64'h0, 8'hFF, 8'h00, 16'h0F0F);
    repeat (2) @(negedge clk);
    clearStats();
    @(posedge clk);
    #2 rst_n = 1'b1;
    waitBusy("fresh");
    waitIdle("fresh");
    // F=71,E=79,D=5E,C=39,B=7C,A=77,9=6F,8=7F, inverted.
    checkFrame("fresh", 64'h8E86A1C6838890 << 8 | 64'h80, 16'hF0F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
